// File: rtl/beta_fetch_unit.sv
// beta_fetch_unit: instruction fetch stage. Owns the PC, issues in-order word
// requests to instruction memory, buffers the returned words in a small FIFO
// and hands them to the decoder. Redirects flush the buffer and drop stale
// in-flight responses.
//
// Handshakes:
//   imem: a request is transferred when imem_req_o && imem_gnt_i in the same
//   cycle. Once raised, imem_req_o and imem_addr_o hold until granted.
//   Responses (imem_rvalid_i) come back in grant order, one per cycle at most.
//   decoder: an instruction is transferred when instr_valid_o && instr_ready_i.
//   instr_valid_o never depends on instr_ready_i.
module beta_fetch_unit #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  BOOT_ADDR = '0,
  parameter int               DEPTH     = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            fetch_en_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            imem_err_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic            fetch_err_o,
  output logic            misaligned_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [1:0]      dbg_state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_MISAL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   req_addr_q;
  logic [XLEN-1:0]   misal_pc_q;
  logic              req_pending_q;
  logic              stale_q;
  logic [CW-1:0]     out_q, out_next;
  logic [CW-1:0]     discard_q;

  logic [XLEN-1:0]   fifo_data_q [DEPTH];
  logic [XLEN-1:0]   fifo_pc_q   [DEPTH];
  logic              fifo_err_q  [DEPTH];
  logic [AW-1:0]     f_wr_q, f_rd_q;
  logic [CW-1:0]     f_cnt_q;

  logic [XLEN-1:0]   txn_pc_q [DEPTH];
  logic [AW-1:0]     t_wr_q, t_rd_q;

  logic room, new_req, gnt_acc, ungranted, push, pop;

  // Request issue and per-cycle transfer events.
  always_comb begin
    room       = ({1'b0, out_q} + {1'b0, f_cnt_q}) < DEPTH_C;
    new_req    = (state_q == ST_RUN) && fetch_en_i && (discard_q == '0) && room;
    imem_req_o = req_pending_q || new_req;
    imem_addr_o = req_pending_q ? req_addr_q : pc_q;
    gnt_acc    = imem_req_o && imem_gnt_i;
    ungranted  = imem_req_o && !imem_gnt_i;
    push       = imem_rvalid_i && (discard_q == '0) && !redirect_i;
    pop        = (state_q != ST_MISAL) && (f_cnt_q != '0) && instr_ready_i;
    out_next   = out_q + CW'(gnt_acc) - CW'(imem_rvalid_i);
  end

  // Next-state logic; a redirect overrides everything else.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = (redirect_pc_i[1:0] == 2'b00) ? ST_RUN : ST_MISAL;
    end else if ((state_q == ST_RUN) && push && imem_err_i) begin
      state_d = ST_HOLD;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // PC, held request and outstanding/discard bookkeeping. A request still
  // waiting for gnt across a redirect is "stale": its grant must neither
  // advance the new PC nor deliver data, so it is pre-counted in discard.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q          <= BOOT_ADDR;
      req_addr_q    <= BOOT_ADDR;
      misal_pc_q    <= '0;
      req_pending_q <= 1'b0;
      stale_q       <= 1'b0;
      out_q         <= '0;
      discard_q     <= '0;
    end else begin
      if (redirect_i) begin
        if (redirect_pc_i[1:0] == 2'b00) pc_q <= redirect_pc_i;
        misal_pc_q <= redirect_pc_i;
      end else if (gnt_acc && !stale_q) begin
        pc_q <= pc_q + XLEN'(4);
      end
      req_pending_q <= ungranted;
      if (ungranted && !req_pending_q) req_addr_q <= pc_q;
      if (redirect_i && ungranted) stale_q <= 1'b1;
      else if (gnt_acc)            stale_q <= 1'b0;
      out_q <= out_next;
      if (redirect_i)                             discard_q <= out_next + CW'(ungranted);
      else if (imem_rvalid_i && discard_q != '0)  discard_q <= discard_q - CW'(1);
    end
  end

  // PC of each in-flight transaction, in grant order; survives redirects so
  // stale responses still retire their slot.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      t_wr_q <= '0;
      t_rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) txn_pc_q[i] <= '0;
    end else begin
      if (gnt_acc) begin
        txn_pc_q[t_wr_q] <= imem_addr_o;
        t_wr_q <= (t_wr_q == LAST_IDX) ? '0 : t_wr_q + AW'(1);
      end
      if (imem_rvalid_i) t_rd_q <= (t_rd_q == LAST_IDX) ? '0 : t_rd_q + AW'(1);
    end
  end

  // Instruction FIFO; a redirect empties it after any same-cycle pop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      f_wr_q  <= '0;
      f_rd_q  <= '0;
      f_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
    end else if (redirect_i) begin
      f_wr_q  <= '0;
      f_rd_q  <= '0;
      f_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[f_wr_q] <= imem_rdata_i;
        fifo_pc_q[f_wr_q]   <= txn_pc_q[t_rd_q];
        fifo_err_q[f_wr_q]  <= imem_err_i;
        f_wr_q <= (f_wr_q == LAST_IDX) ? '0 : f_wr_q + AW'(1);
      end
      if (pop) f_rd_q <= (f_rd_q == LAST_IDX) ? '0 : f_rd_q + AW'(1);
      f_cnt_q <= f_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Decoder-facing outputs: synthetic NOP in MISAL, else the FIFO head.
  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = '0;
    instr_pc_o    = '0;
    fetch_err_o   = 1'b0;
    misaligned_o  = 1'b0;
    if (state_q == ST_MISAL) begin
      instr_valid_o = 1'b1;
      instr_o       = XLEN'(32'h0000_0013);
      instr_pc_o    = misal_pc_q;
      misaligned_o  = 1'b1;
    end else if (f_cnt_q != '0) begin
      instr_valid_o = 1'b1;
      instr_o       = fifo_data_q[f_rd_q];
      instr_pc_o    = fifo_pc_q[f_rd_q];
      fetch_err_o   = fifo_err_q[f_rd_q];
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_beta_fetch_unit.sv
// tb_beta_fetch_unit: directed bench for beta_fetch_unit with a small in-order
// memory model (data word = ~address) and an expected-PC scoreboard.
module tb_beta_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn_i, fetch_en_i, imem_req_o, imem_gnt_i, imem_rvalid_i, imem_err_i;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, instr_pc_o, redirect_pc_i;
  logic        instr_valid_o, instr_ready_i, fetch_err_o, misaligned_o, redirect_i;
  logic [1:0]  dbg_state_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] mem_q[$];
  int          n_deliv = 0;
  int          out_cnt = 0;
  logic        mem_stall = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFF0;

  // Clock.
  always #5 clk = ~clk;

  beta_fetch_unit #(.XLEN(32), .BOOT_ADDR(32'h0), .DEPTH(2)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .fetch_en_i(fetch_en_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .fetch_err_o(fetch_err_o), .misaligned_o(misaligned_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .dbg_state_o(dbg_state_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: a grant seen before edge T is answered in the cycle after T
  // unless stalled; responses leave in grant order.
  always begin : mem_model
    logic        g_now;
    logic [31:0] g_addr, a;
    @(negedge clk);
    g_now  = rstn_i && imem_req_o && imem_gnt_i;
    g_addr = imem_addr_o;
    @(posedge clk);
    #2;
    if (!rstn_i) begin
      mem_q.delete();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0; imem_err_i = 1'b0;
    end else begin
      if (g_now) mem_q.push_back(g_addr);
      if (!mem_stall && mem_q.size() > 0) begin
        a = mem_q.pop_front();
        imem_rvalid_i = 1'b1; imem_rdata_i = ~a; imem_err_i = (a == err_addr);
      end else begin
        imem_rvalid_i = 1'b0; imem_rdata_i = '0; imem_err_i = 1'b0;
      end
    end
  end

  // Monitor and scoreboard: logs grants, bounds outstanding, checks deliveries.
  always @(negedge clk) begin
    if (!rstn_i) begin
      out_cnt = 0;
      gnt_log.delete();
    end else begin
      if (imem_req_o && imem_gnt_i) begin
        gnt_log.push_back(imem_addr_o);
        out_cnt++;
        check_eq("max_outstanding", 32'(out_cnt <= 2), 32'd1);
      end
      if (imem_rvalid_i) out_cnt--;
      if (instr_valid_o && instr_ready_i && !misaligned_o) begin
        n_deliv++;
        check_eq("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [31:0] epc;
          logic        eerr;
          epc  = exp_q.pop_front();
          eerr = exp_err_q.pop_front();
          check_eq("instr_pc", instr_pc_o, epc);
          check_eq("instr_word", instr_o, ~epc);
          check_eq("fetch_err", 32'(fetch_err_o), 32'(eerr));
        end
      end
    end
  end

  // Driver tasks.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc, input logic err);
    exp_q.push_back(pc);
    exp_err_q.push_back(err);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; fetch_en_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    instr_ready_i = 1'b1; imem_gnt_i = 1'b1; mem_stall = 1'b0; err_addr = 32'hFFFF_FFF0;
    exp_q.delete(); exp_err_q.delete(); n_deliv = 0;
    tick(2);
    rstn_i = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_i = 1'b1; redirect_pc_i = pc;
    tick(1);
    redirect_i = 1'b0;
  endtask

  task automatic wait_deliv(input int target, input string tag);
    for (int c = 0; c < 200 && n_deliv < target; c++) tick(1);
    check_eq(tag, 32'(n_deliv), 32'(target));
  endtask

  task automatic wait_out(input int target, input string tag);
    for (int c = 0; c < 50 && out_cnt < target; c++) tick(1);
    check_eq(tag, 32'(out_cnt), 32'(target));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rstn_i = 1'b0; fetch_en_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    instr_ready_i = 1'b1; imem_gnt_i = 1'b1;
    tick(2);
    // Reset values.
    @(negedge clk);
    check_eq("rst_req", 32'(imem_req_o), 32'd0);
    check_eq("rst_addr", imem_addr_o, 32'h0);
    check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_pc", instr_pc_o, 32'h0);
    check_eq("rst_err", 32'(fetch_err_o), 32'd0);
    check_eq("rst_mis", 32'(misaligned_o), 32'd0);
    check_eq("rst_state", 32'(dbg_state_o), 32'd0);

    // Streaming fetch from BOOT_ADDR.
    tick(1);
    for (int i = 0; i < 16; i++) expect_pc(32'(i * 4), 1'b0);
    rstn_i = 1'b1; fetch_en_i = 1'b1;
    wait_deliv(8, "p1_delivered");
    for (int i = 0; i < 4; i++) check_eq("p1_gnt_addr", gnt_log[i], 32'(i * 4));

    // Decoder stalls: buffer fills, requests stop, order preserved on release.
    do_reset();
    instr_ready_i = 1'b0; fetch_en_i = 1'b1;
    tick(10);
    @(negedge clk);
    check_eq("p2_valid", 32'(instr_valid_o), 32'd1);
    check_eq("p2_head_pc", instr_pc_o, 32'h0);
    check_eq("p2_req_low", 32'(imem_req_o), 32'd0);
    tick(1);
    check_eq("p2_outstanding", 32'(out_cnt), 32'd0);
    for (int i = 0; i < 4; i++) expect_pc(32'(i * 4), 1'b0);
    instr_ready_i = 1'b1;
    wait_deliv(4, "p2_delivered");

    // Redirect with two responses in flight.
    do_reset();
    mem_stall = 1'b1;
    redirect_to(32'h10);
    fetch_en_i = 1'b1;
    wait_out(2, "p3_in_flight");
    check_eq("p3_gnt0", gnt_log[0], 32'h10);
    check_eq("p3_gnt1", gnt_log[1], 32'h14);
    expect_pc(32'h100, 1'b0); expect_pc(32'h104, 1'b0);
    redirect_to(32'h100);
    mem_stall = 1'b0;
    wait_deliv(2, "p3_delivered");

    // Redirect in the same cycle as the rvalid for 0x20.
    do_reset();
    mem_stall = 1'b1;
    redirect_to(32'h20);
    fetch_en_i = 1'b1;
    wait_out(2, "p4_in_flight");
    check_eq("p4_gnt0", gnt_log[0], 32'h20);
    expect_pc(32'h300, 1'b0); expect_pc(32'h304, 1'b0);
    mem_stall = 1'b0;
    redirect_to(32'h300);
    wait_deliv(2, "p4_delivered");

    // Redirect in the same cycle as a grant.
    do_reset();
    fetch_en_i = 1'b1; mem_stall = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h500;
    @(negedge clk);
    check_eq("p5_req_with_redirect", 32'(imem_req_o), 32'd1);
    check_eq("p5_addr_with_redirect", imem_addr_o, 32'h0);
    tick(1);
    redirect_i = 1'b0; mem_stall = 1'b0;
    expect_pc(32'h500, 1'b0); expect_pc(32'h504, 1'b0);
    wait_deliv(2, "p5_delivered");
    check_eq("p5_gnt1", gnt_log[1], 32'h500);

    // Ungranted request survives a redirect and is dropped on return.
    do_reset();
    imem_gnt_i = 1'b0; fetch_en_i = 1'b1;
    @(negedge clk);
    check_eq("p6_req_up", 32'(imem_req_o), 32'd1);
    tick(1);
    redirect_i = 1'b1; redirect_pc_i = 32'h600;
    @(negedge clk);
    check_eq("p6_addr_during_redirect", imem_addr_o, 32'h0);
    tick(1);
    redirect_i = 1'b0;
    @(negedge clk);
    check_eq("p6_req_held", 32'(imem_req_o), 32'd1);
    check_eq("p6_addr_held", imem_addr_o, 32'h0);
    tick(1);
    imem_gnt_i = 1'b1;
    expect_pc(32'h600, 1'b0); expect_pc(32'h604, 1'b0);
    wait_deliv(2, "p6_delivered");
    check_eq("p6_gnt0", gnt_log[0], 32'h0);
    check_eq("p6_gnt1", gnt_log[1], 32'h600);

    // Access fault at 0x40: delivered with error, fetch halts until redirect.
    do_reset();
    err_addr = 32'h40;
    redirect_to(32'h40);
    expect_pc(32'h40, 1'b1); expect_pc(32'h44, 1'b0);
    fetch_en_i = 1'b1;
    wait_deliv(2, "p7_delivered");
    begin
      int g0;
      g0 = gnt_log.size();
      tick(6);
      check_eq("p7_grants_before_hold", 32'(g0), 32'd2);
      check_eq("p7_no_req_in_hold", 32'(gnt_log.size()), 32'(g0));
    end
    check_eq("p7_state_hold", 32'(dbg_state_o), 32'd1);
    expect_pc(32'h80, 1'b0); expect_pc(32'h84, 1'b0);
    redirect_to(32'h80);
    wait_deliv(4, "p7_resumed");

    // Misaligned redirect: synthetic NOP held until the next redirect.
    do_reset();
    instr_ready_i = 1'b0; fetch_en_i = 1'b1;
    tick(6);
    redirect_to(32'h102);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("p8_valid", 32'(instr_valid_o), 32'd1);
      check_eq("p8_nop", instr_o, 32'h0000_0013);
      check_eq("p8_pc", instr_pc_o, 32'h102);
      check_eq("p8_mis", 32'(misaligned_o), 32'd1);
      check_eq("p8_no_req", 32'(imem_req_o), 32'd0);
    end
    tick(1);
    check_eq("p8_state_misal", 32'(dbg_state_o), 32'd2);
    expect_pc(32'h200, 1'b0); expect_pc(32'h204, 1'b0);
    redirect_to(32'h200);
    wait_deliv(2, "p8_recovered");

    rstn_i = 1'b0;
    tick(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
